// File: rtl/vram_writer_pkg.sv
// Shared encodings for the button-driven VRAM writer.
// FSM states, pattern codes and the pattern bit-pair helper.
package vram_writer_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SINGLE   = 2'd1;
  localparam logic [1:0] FILL     = 2'd2;
  localparam logic [1:0] FILL_GAP = 2'd3;

  localparam logic [1:0] PAT_ZERO  = 2'd0;
  localparam logic [1:0] PAT_ONES  = 2'd1;
  localparam logic [1:0] PAT_ALT   = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Every pattern is a 2-bit unit replicated across the word.
  function automatic logic [1:0] pat_unit(
    input logic [1:0] pat,
    input logic       a0
  );
    logic [1:0] u;
    unique case (pat)
      PAT_ZERO:  u = 2'b00;
      PAT_ONES:  u = 2'b11;
      PAT_ALT:   u = 2'b10;
      PAT_CHECK: u = a0 ? 2'b11 : 2'b00;
      default:   u = 2'b00;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stable-count debouncer and press pulse.
// Ports: clk, reset (async high), raw in; level, pulse out.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of differing samples already seen;
  // the level flips on the DEBOUNCE_CYCLES-th one in a row.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/vram_button_writer.sv
// Button-driven VRAM write controller: single write and full fill.
// Ports: clk, reset, four raw buttons, wren/waddr/wdata/wrack, status.
module vram_button_writer
  import vram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 14,
  parameter int DATA_WIDTH      = 16,
  parameter int DEPTH           = 8192,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_write,
  input  logic                  btn_next,
  input  logic                  btn_pattern,
  input  logic                  btn_fill,
  output logic                  wren,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wrack,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] cursor,
  output logic [1:0]            pattern_sel
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  function automatic logic [DATA_WIDTH-1:0] pat_word(
    input logic [1:0] p,
    input logic       a0
  );
    return {(DATA_WIDTH/2){pat_unit(p, a0)}};
  endfunction

  logic [3:0] raw;
  logic [3:0] pls;
  logic [3:0] lvl_unused;

  assign raw = {btn_fill, btn_pattern, btn_next, btn_write};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .level(lvl_unused[i]),
      .pulse(pls[i])
    );
  end

  logic write_p, next_p, pat_p, fill_p;
  assign write_p = pls[0];
  assign next_p  = pls[1];
  assign pat_p   = pls[2];
  assign fill_p  = pls[3];

  logic [1:0]            state_q, state_d;
  logic                  wren_q, wren_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [1:0]            pat_q, pat_d;

  always_comb begin
    state_d     = state_q;
    wren_d      = wren_q;
    busy_d      = busy_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cursor_d    = cursor_q;
    fill_addr_d = fill_addr_q;
    pat_d       = pat_q;
    unique case (state_q)
      IDLE: begin
        // Cursor/pattern updates apply alongside a launch but the
        // launch uses the pre-update values.
        if (next_p)
          cursor_d = (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
        if (pat_p)
          pat_d = pat_q + 2'd1;
        if (fill_p) begin
          state_d     = FILL;
          fill_addr_d = '0;
          waddr_d     = '0;
          wdata_d     = pat_word(pat_q, 1'b0);
          wren_d      = 1'b1;
          busy_d      = 1'b1;
        end else if (write_p) begin
          state_d = SINGLE;
          waddr_d = cursor_q;
          wdata_d = pat_word(pat_q, cursor_q[0]);
          wren_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SINGLE: begin
        if (wrack) begin
          wren_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      FILL: begin
        if (wrack) begin
          wren_d = 1'b0;
          if (fill_addr_q == LAST) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            fill_addr_d = fill_addr_q + 1'b1;
            state_d     = FILL_GAP;
          end
        end
      end
      FILL_GAP: begin
        waddr_d = fill_addr_q;
        wdata_d = pat_word(pat_q, fill_addr_q[0]);
        wren_d  = 1'b1;
        state_d = FILL;
      end
      default: begin
        state_d = IDLE;
        wren_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cursor_q    <= '0;
      fill_addr_q <= '0;
      pat_q       <= PAT_ZERO;
    end else begin
      state_q     <= state_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cursor_q    <= cursor_d;
      fill_addr_q <= fill_addr_d;
      pat_q       <= pat_d;
    end
  end

  assign wren        = wren_q;
  assign busy        = busy_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign cursor      = cursor_q;
  assign pattern_sel = pat_q;

endmodule

// File: doc/vram_button_writer.md
Name: vram_button_writer

Overview:
Button-driven VRAM write controller for board bring-up. Debounces raw push-buttons, keeps a cursor address and a pattern selection, and issues write requests on the VRAM write port using the wren/wrack handshake. Supports a single-word write at the cursor and a full-screen fill. It sits between the board buttons and the VRAM write port in the Computer top level, on the PLL clock domain.

Parameters:
ADDR_WIDTH, 14, width of waddr and cursor.
DATA_WIDTH, 16, width of wdata; must be even.
DEPTH, 8192, number of writable words; valid addresses are 0..DEPTH-1; DEPTH <= 2**ADDR_WIDTH.
DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a level change (~10 ms at 25.125 MHz); must be >= 2.

Ports:
clk  in  1  system clock (PLL output)
reset  in  1  asynchronous, active-high reset
btn_write  in  1  raw button: write one word at the cursor
btn_next  in  1  raw button: advance the cursor
btn_pattern  in  1  raw button: cycle the data pattern
btn_fill  in  1  raw button: fill all DEPTH words
wren  out  1  write request to VRAM
waddr  out  ADDR_WIDTH  write address
wdata  out  DATA_WIDTH  write data
wrack  in  1  one-cycle write acknowledge from VRAM
busy  out  1  high while a write or fill is in progress
cursor  out  ADDR_WIDTH  current cursor address
pattern_sel  out  2  current pattern code

Behaviour:
- Reset values: wren=0, waddr=0, wdata=0, busy=0, cursor=0, pattern_sel=0, FSM=IDLE, all synchroniser and debounce state 0. Reset mid-operation aborts at once: wren drops asynchronously and no resume happens.
- Each button passes through a 2-flop synchroniser and then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current level.
  - A shorter disturbance restarts the count.
  - A 0->1 change of the debounced level produces a one-cycle pulse. Release produces no pulse.
- Pattern data as a function of address a:
  - 0 = all zeros
  - 1 = all ones
  - 2 = repeated 2'b10 (16'hAAAA at default width)
  - 3 = a[0] ? all ones : all zeros
- The pattern_sel pulse increments pattern_sel modulo 4.
- The next pulse sets cursor = (cursor == DEPTH-1) ? 0 : cursor+1. The cursor never reaches DEPTH.
- FSM states: IDLE, SINGLE, FILL, FILL_GAP.
  - IDLE: busy=0, wren=0.
    - A fill pulse goes to FILL with fill_addr=0.
    - Otherwise a write pulse goes to SINGLE.
    - If both arrive in the same cycle, fill wins.
    - On entry the controller registers waddr and wdata (pattern computed from the pre-update cursor and pattern_sel), then sets wren=1 and busy=1 on the next edge.
  - Next and pattern pulses arriving in IDLE in the same cycle as write or fill are still applied. They affect only later operations.
  - SINGLE: holds wren, waddr and wdata stable until wrack=1. On that edge, wren goes to 0, busy goes to 0, and the FSM returns to IDLE.
  - FILL: as SINGLE, but on wrack:
    - if fill_addr == DEPTH-1: return to IDLE.
    - else: fill_addr increments, wren goes to 0, and the FSM enters FILL_GAP.
  - FILL_GAP: lasts exactly one cycle with wren=0. It loads waddr=fill_addr and wdata=pattern(fill_addr), then re-asserts wren and returns to FILL.
- Each FILL write therefore takes the ack latency plus 2 cycles. The cursor is unchanged by a fill.
- While busy=1, all button pulses (write, fill, next, pattern) are discarded, not queued.
- wrack is ignored while wren=0. No new request is issued in the cycle after an ack.

Decomposition:
- Package vram_writer_pkg holds:
  - FSM state encodings: IDLE, SINGLE, FILL, FILL_GAP.
  - Pattern codes: PAT_ZERO=0, PAT_ONES=1, PAT_ALT=2, PAT_CHECK=3.
- Sub-module button_debouncer: synchroniser, debounce counter and rising-edge pulse. Parameter DEBOUNCE_CYCLES, ports clk, reset, raw, level, pulse. Instantiated four times.

Test Plan:
- DEBOUNCE_CYCLES=4. A btn_next glitch high for 3 cycles -> no pulse, cursor stays 0. A hold of 6 cycles -> cursor=1, exactly one increment.
- Pattern 1, cursor 5, btn_write. VRAM acks 3 cycles after wren -> wren=1, waddr=5, wdata=16'hFFFF held until wrack; wren=0 and busy=0 one edge later; cursor still 5.
- DEPTH=8, cursor=7, btn_next -> cursor=0, never 8.
- DEPTH=8, pattern 3, btn_fill, immediate acks -> 8 writes to addresses 0..7 with data 0000, FFFF, 0000, ... One wren=0 cycle separates consecutive writes, then busy=0.
- During a fill with DEPTH=8, pulse btn_next, btn_pattern and btn_write -> cursor, pattern_sel and the write sequence are all unchanged.
- Assert reset while wren=1 at fill address 3 -> wren=0 immediately and all outputs at reset values. After release with no buttons pressed, no wren occurs.
